// File: rtl/ic_csr_mn_s1.sv
// CSR-bus interconnect: NMST masters share one CSR slave through a round-robin
// or fixed-priority arbiter, with the grant locked until the response completes.
module ic_csr_mn_s1 #(
  parameter int unsigned NMST             = 4,
  parameter int unsigned ARB_RR           = 1,
  parameter int unsigned TIMEOUT          = 0,
  parameter int unsigned CsrReq_TotalBits = 10,
  parameter int unsigned RISCV_ARCH       = 64
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [NMST-1:0]                    i_m_req_valid,
  output logic [NMST-1:0]                    o_m_req_ready,
  input  logic [NMST*CsrReq_TotalBits-1:0]   i_m_req_type,
  input  logic [NMST*12-1:0]                 i_m_req_addr,
  input  logic [NMST*RISCV_ARCH-1:0]         i_m_req_data,
  output logic [NMST-1:0]                    o_m_resp_valid,
  input  logic [NMST-1:0]                    i_m_resp_ready,
  output logic [NMST*RISCV_ARCH-1:0]         o_m_resp_data,
  output logic [NMST-1:0]                    o_m_resp_exception,
  output logic                               o_s0_req_valid,
  input  logic                               i_s0_req_ready,
  output logic [CsrReq_TotalBits-1:0]        o_s0_req_type,
  output logic [11:0]                        o_s0_req_addr,
  output logic [RISCV_ARCH-1:0]              o_s0_req_data,
  input  logic                               i_s0_resp_valid,
  output logic                               o_s0_resp_ready,
  input  logic [RISCV_ARCH-1:0]              i_s0_resp_data,
  input  logic                               i_s0_resp_exception,
  output logic                               o_timeout
);

  localparam int unsigned IW       = $clog2(NMST);
  localparam logic [7:0]  TMO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [IW-1:0]     midx_q, midx_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [7:0]        tmo_cnt_q, tmo_cnt_d;
  logic              tmo_pulse_q, tmo_pulse_d;

  logic [IW-1:0]     arb_base;
  logic [2*NMST-1:0] req_rot;
  logic [IW-1:0]     win_idx;
  logic              win_vld;
  logic [IW-1:0]     rr_next;
  logic [IW-1:0]     fwd_idx;
  logic              fwd_en;

  // Rotating the valid vector by the pointer turns round-robin into a lowest-set-bit search.
  assign arb_base = (ARB_RR != 0) ? rr_ptr_q : '0;
  assign req_rot  = {i_m_req_valid, i_m_req_valid} >> arb_base;
  assign rr_next  = IW'((32'(midx_q) + 32'd1) % NMST);

  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    for (int unsigned i = 0; i < NMST; i++) begin
      if (!win_vld && req_rot[i]) begin
        win_vld = 1'b1;
        win_idx = IW'((32'(arb_base) + i) % NMST);
      end
    end
  end

  always_comb begin
    state_d            = state_q;
    midx_d             = midx_q;
    rr_ptr_d           = rr_ptr_q;
    tmo_cnt_d          = tmo_cnt_q;
    tmo_pulse_d        = 1'b0;
    fwd_en             = 1'b0;
    fwd_idx            = midx_q;
    o_m_req_ready      = '0;
    o_m_resp_valid     = '0;
    o_m_resp_data      = '0;
    o_m_resp_exception = '0;
    o_s0_resp_ready    = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_vld) begin
          fwd_en  = 1'b1;
          fwd_idx = win_idx;
          midx_d  = win_idx;
          state_d = i_s0_req_ready ? RESP : REQ;
        end
      end
      REQ: begin
        fwd_en = 1'b1;
        if (i_s0_req_ready) begin
          state_d = RESP;
        end
      end
      RESP: begin
        o_s0_resp_ready = i_m_resp_ready[midx_q];
        if (i_s0_resp_valid && i_m_resp_ready[midx_q]) begin
          state_d   = IDLE;
          tmo_cnt_d = '0;
          if (ARB_RR != 0) begin
            rr_ptr_d = rr_next;
          end
        end else if ((TIMEOUT != 0) && !i_s0_resp_valid) begin
          // A stalled-but-valid response freezes the counter; only silence ages it.
          if (tmo_cnt_q == TMO_LAST) begin
            state_d     = ERR;
            tmo_cnt_d   = '0;
            tmo_pulse_d = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
          end
        end
      end
      ERR: begin
        o_s0_resp_ready = 1'b1;
        if (i_m_resp_ready[midx_q]) begin
          state_d = IDLE;
          if (ARB_RR != 0) begin
            rr_ptr_d = rr_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    for (int unsigned k = 0; k < NMST; k++) begin
      if (fwd_en && (IW'(k) == fwd_idx)) begin
        o_m_req_ready[k] = i_s0_req_ready;
      end
      if (IW'(k) == midx_q) begin
        if (state_q == RESP) begin
          o_m_resp_valid[k]                          = i_s0_resp_valid;
          o_m_resp_data[k*RISCV_ARCH +: RISCV_ARCH]  = i_s0_resp_data;
          o_m_resp_exception[k]                      = i_s0_resp_exception;
        end else if (state_q == ERR) begin
          o_m_resp_valid[k]     = 1'b1;
          o_m_resp_exception[k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    o_s0_req_type = '0;
    o_s0_req_addr = '0;
    o_s0_req_data = '0;
    for (int unsigned k = 0; k < NMST; k++) begin
      if (fwd_en && (IW'(k) == fwd_idx)) begin
        o_s0_req_type = i_m_req_type[k*CsrReq_TotalBits +: CsrReq_TotalBits];
        o_s0_req_addr = i_m_req_addr[k*12 +: 12];
        o_s0_req_data = i_m_req_data[k*RISCV_ARCH +: RISCV_ARCH];
      end
    end
  end

  assign o_s0_req_valid = fwd_en;
  assign o_timeout      = tmo_pulse_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      midx_q      <= '0;
      rr_ptr_q    <= '0;
      tmo_cnt_q   <= '0;
      tmo_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      midx_q      <= midx_d;
      rr_ptr_q    <= rr_ptr_d;
      tmo_cnt_q   <= tmo_cnt_d;
      tmo_pulse_q <= tmo_pulse_d;
    end
  end

endmodule

// File: tb/tb_ic_csr_mn_s1.sv
// Directed bench for ic_csr_mn_s1: round-robin/watchdog instance and a fixed-priority
// instance share stimulus; expected responses are queued when requests are set up.
module tb_ic_csr_mn_s1;

  localparam int NM = 4;
  localparam int CW = 10;
  localparam int XW = 64;
  localparam logic [XW-1:0] MASK = 64'hFFFF_0000_FFFF_0000;

  typedef struct {
    int            m;
    logic [XW-1:0] rq;
    logic [XW-1:0] rsp;
    logic          exc;
  } exp_t;

  exp_t sb[$];

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic sel_fp = 1'b0;

  logic [NM-1:0]    m_req_valid;
  logic [NM*CW-1:0] m_req_type;
  logic [NM*12-1:0] m_req_addr;
  logic [NM*XW-1:0] m_req_data;
  logic [NM-1:0]    m_resp_ready;
  logic             s0_req_ready;
  logic             s0_resp_valid;
  logic [XW-1:0]    s0_resp_data;
  logic             s0_resp_exc;

  logic [NM-1:0]    a_req_ready, a_resp_valid, a_resp_exc;
  logic [NM*XW-1:0] a_resp_data;
  logic             a_s0_req_valid, a_s0_resp_ready, a_timeout;
  logic [CW-1:0]    a_s0_req_type;
  logic [11:0]      a_s0_req_addr;
  logic [XW-1:0]    a_s0_req_data;

  logic [NM-1:0]    b_req_ready, b_resp_valid, b_resp_exc;
  logic [NM*XW-1:0] b_resp_data;
  logic             b_s0_req_valid, b_s0_resp_ready, b_timeout;
  logic [CW-1:0]    b_s0_req_type;
  logic [11:0]      b_s0_req_addr;
  logic [XW-1:0]    b_s0_req_data;

  logic [NM-1:0]    obs_req_ready, obs_resp_valid, obs_resp_exc;
  logic [NM*XW-1:0] obs_resp_data;
  logic             obs_s0_req_valid, obs_s0_resp_ready, obs_timeout;
  logic [CW-1:0]    obs_s0_req_type;
  logic [11:0]      obs_s0_req_addr;
  logic [XW-1:0]    obs_s0_req_data;

  assign obs_req_ready     = sel_fp ? b_req_ready     : a_req_ready;
  assign obs_resp_valid    = sel_fp ? b_resp_valid    : a_resp_valid;
  assign obs_resp_exc      = sel_fp ? b_resp_exc      : a_resp_exc;
  assign obs_resp_data     = sel_fp ? b_resp_data     : a_resp_data;
  assign obs_s0_req_valid  = sel_fp ? b_s0_req_valid  : a_s0_req_valid;
  assign obs_s0_resp_ready = sel_fp ? b_s0_resp_ready : a_s0_resp_ready;
  assign obs_timeout       = sel_fp ? b_timeout       : a_timeout;
  assign obs_s0_req_type   = sel_fp ? b_s0_req_type   : a_s0_req_type;
  assign obs_s0_req_addr   = sel_fp ? b_s0_req_addr   : a_s0_req_addr;
  assign obs_s0_req_data   = sel_fp ? b_s0_req_data   : a_s0_req_data;

  ic_csr_mn_s1 #(.NMST(NM), .ARB_RR(1), .TIMEOUT(8), .CsrReq_TotalBits(CW), .RISCV_ARCH(XW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m_req_valid(m_req_valid), .o_m_req_ready(a_req_ready),
    .i_m_req_type(m_req_type), .i_m_req_addr(m_req_addr), .i_m_req_data(m_req_data),
    .o_m_resp_valid(a_resp_valid), .i_m_resp_ready(m_resp_ready),
    .o_m_resp_data(a_resp_data), .o_m_resp_exception(a_resp_exc),
    .o_s0_req_valid(a_s0_req_valid), .i_s0_req_ready(s0_req_ready),
    .o_s0_req_type(a_s0_req_type), .o_s0_req_addr(a_s0_req_addr), .o_s0_req_data(a_s0_req_data),
    .i_s0_resp_valid(s0_resp_valid), .o_s0_resp_ready(a_s0_resp_ready),
    .i_s0_resp_data(s0_resp_data), .i_s0_resp_exception(s0_resp_exc),
    .o_timeout(a_timeout)
  );

  ic_csr_mn_s1 #(.NMST(NM), .ARB_RR(0), .TIMEOUT(0), .CsrReq_TotalBits(CW), .RISCV_ARCH(XW)) dut_fp (
    .i_clk(clk), .i_rst(rst),
    .i_m_req_valid(m_req_valid), .o_m_req_ready(b_req_ready),
    .i_m_req_type(m_req_type), .i_m_req_addr(m_req_addr), .i_m_req_data(m_req_data),
    .o_m_resp_valid(b_resp_valid), .i_m_resp_ready(m_resp_ready),
    .o_m_resp_data(b_resp_data), .o_m_resp_exception(b_resp_exc),
    .o_s0_req_valid(b_s0_req_valid), .i_s0_req_ready(s0_req_ready),
    .o_s0_req_type(b_s0_req_type), .o_s0_req_addr(b_s0_req_addr), .o_s0_req_data(b_s0_req_data),
    .i_s0_resp_valid(s0_resp_valid), .o_s0_resp_ready(b_s0_resp_ready),
    .i_s0_resp_data(s0_resp_data), .i_s0_resp_exception(s0_resp_exc),
    .o_timeout(b_timeout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  logic [XW-1:0] cap;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [XW-1:0] mdata(input int k);
    return 64'h0123_4567_89AB_CDE0 + 64'(k) * 64'h0000_0101_0000_0011;
  endfunction

  task automatic push(input int m, input logic exc, input bit tmo);
    exp_t e;
    e.m   = m;
    e.rq  = mdata(m);
    e.rsp = tmo ? '0 : (mdata(m) ^ MASK);
    e.exc = tmo ? 1'b1 : exc;
    sb.push_back(e);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req_ready"}, obs_req_ready, 0);
    chk({tag, "_resp_valid"}, obs_resp_valid, 0);
    chk({tag, "_resp_data"}, obs_resp_data, 0);
    chk({tag, "_resp_exc"}, obs_resp_exc, 0);
    chk({tag, "_s0_req_valid"}, obs_s0_req_valid, 0);
    chk({tag, "_s0_resp_ready"}, obs_s0_resp_ready, 0);
    chk({tag, "_timeout"}, obs_timeout, 0);
  endtask

  // Waits (bounded) for the expected master's request at s0 and completes its handshake.
  task automatic accept();
    exp_t e;
    int   n;
    e = sb[0];
    s0_req_ready = 1'b1;
    #1;
    n = 0;
    while (obs_s0_req_valid !== 1'b1 && n < 20) begin
      nxt();
      #1;
      n++;
    end
    chk("s0_req_valid", obs_s0_req_valid, 1);
    chk("grant", obs_req_ready, 256'(1) << e.m);
    chk("s0_req_data", obs_s0_req_data, e.rq);
    chk("s0_req_addr", obs_s0_req_addr, 12'h300 + 12'(e.m));
    chk("s0_req_type", obs_s0_req_type, CW'(e.m + 1));
    cap = obs_s0_req_data;
    nxt();
    chk("resp_no_fwd", obs_s0_req_valid, 0);
  endtask

  // Slave answers after lat silent cycles; master withholds resp_ready for hold cycles.
  task automatic respond(input int lat, input int hold);
    exp_t e;
    logic [NM*XW-1:0] ed;
    e = sb.pop_front();
    repeat (lat) begin
      #1;
      chk("wait_resp_valid", obs_resp_valid, 0);
      chk("wait_timeout", obs_timeout, 0);
      nxt();
    end
    s0_resp_valid = 1'b1;
    s0_resp_data  = cap ^ MASK;
    s0_resp_exc   = e.exc;
    if (hold > 0) begin
      m_resp_ready[e.m] = 1'b0;
      repeat (hold) begin
        #1;
        chk("held_resp_valid", obs_resp_valid, 256'(1) << e.m);
        chk("held_s0_resp_ready", obs_s0_resp_ready, 0);
        chk("held_timeout", obs_timeout, 0);
        nxt();
      end
      m_resp_ready[e.m] = 1'b1;
    end
    #1;
    ed = '0;
    ed[e.m*XW +: XW] = e.rsp;
    chk("resp_valid", obs_resp_valid, 256'(1) << e.m);
    chk("resp_data", obs_resp_data, ed);
    chk("resp_exc", obs_resp_exc, e.exc ? (256'(1) << e.m) : 256'(0));
    chk("s0_resp_ready", obs_s0_resp_ready, 1);
    nxt();
    s0_resp_valid = 1'b0;
    s0_resp_exc   = 1'b0;
    #1;
    chk("post_resp_timeout", obs_timeout, 0);
  endtask

  // Masters must hold valid and payload until accepted (outside reset).
  logic [NM-1:0]    pv, pr;
  logic [NM*XW-1:0] pd;
  logic             prst;
  always @(posedge clk) begin
    pv   <= m_req_valid;
    pr   <= obs_req_ready;
    pd   <= m_req_data;
    prst <= rst;
  end
  always @(negedge clk) begin
    if (rst === 1'b0 && prst === 1'b0) begin
      for (int k = 0; k < NM; k++) begin
        if (pv[k] && !pr[k]) begin
          chk("master_hold", {m_req_valid[k], m_req_data[k*XW +: XW]}, {1'b1, pd[k*XW +: XW]});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic [NM*XW-1:0] ed;
    m_req_valid   = '0;
    m_resp_ready  = '1;
    s0_req_ready  = 1'b1;
    s0_resp_valid = 1'b0;
    s0_resp_data  = '0;
    s0_resp_exc   = 1'b0;
    for (int k = 0; k < NM; k++) begin
      m_req_type[k*CW +: CW] = CW'(k + 1);
      m_req_addr[k*12 +: 12] = 12'h300 + 12'(k);
      m_req_data[k*XW +: XW] = mdata(k);
    end

    // Reset state
    do_reset();
    #1;
    chk_idle("reset");

    // Round-robin with all masters valid: 0,1,2,3,0
    nxt();
    m_req_valid = 4'b1111;
    push(0, 1'b0, 1'b0);
    push(1, 1'b0, 1'b0);
    push(2, 1'b0, 1'b0);
    push(3, 1'b1, 1'b0);
    push(0, 1'b0, 1'b0);
    repeat (5) begin
      accept();
      respond(1, 0);
    end

    // Fixed priority: master 1 wins repeatedly, master 3 starved
    m_req_valid = '0;
    sel_fp = 1'b1;
    do_reset();
    m_req_valid = 4'b1010;
    repeat (3) begin
      push(1, 1'b0, 1'b0);
      accept();
      respond(1, 0);
    end
    m_req_valid = '0;
    sel_fp = 1'b0;
    do_reset();

    // Grant lock: master 2 waits in REQ while master 0 raises valid
    s0_req_ready = 1'b0;
    m_req_valid  = 4'b0100;
    push(2, 1'b0, 1'b0);
    push(0, 1'b0, 1'b0);
    #1;
    chk("lock_fwd_valid", obs_s0_req_valid, 1);
    chk("lock_req_ready", obs_req_ready, 0);
    nxt();
    m_req_valid[0] = 1'b1;
    repeat (3) begin
      #1;
      chk("lock_addr", obs_s0_req_addr, 12'h302);
      chk("lock_data", obs_s0_req_data, mdata(2));
      chk("lock_req_ready", obs_req_ready, 0);
      nxt();
    end
    accept();
    m_req_valid[2] = 1'b0;
    respond(1, 0);
    accept();
    m_req_valid[0] = 1'b0;
    respond(1, 0);

    // Watchdog fires after 8 silent RESP cycles
    do_reset();
    m_req_valid = 4'b0001;
    push(0, 1'b0, 1'b1);
    accept();
    m_req_valid[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("tmo_wait_pulse", obs_timeout, 0);
      chk("tmo_wait_resp_valid", obs_resp_valid, 0);
      nxt();
      #1;
    end
    s0_resp_valid = 1'b1;
    s0_resp_data  = '1;
    #1;
    e  = sb.pop_front();
    ed = '0;
    ed[e.m*XW +: XW] = e.rsp;
    chk("tmo_pulse", obs_timeout, 1);
    chk("tmo_resp_valid", obs_resp_valid, 256'(1) << e.m);
    chk("tmo_resp_data", obs_resp_data, ed);
    chk("tmo_resp_exc", obs_resp_exc, 256'(1) << e.m);
    chk("tmo_s0_resp_ready", obs_s0_resp_ready, 1);
    nxt();
    s0_resp_valid = 1'b0;
    s0_resp_data  = '0;
    #1;
    chk("tmo_pulse_end", obs_timeout, 0);
    chk("tmo_back_idle", obs_resp_valid, 0);

    // Normal traffic after the timeout, then a response on the last allowed cycle
    m_req_valid = 4'b0010;
    push(1, 1'b0, 1'b0);
    accept();
    m_req_valid[1] = 1'b0;
    respond(2, 0);
    m_req_valid = 4'b0100;
    push(2, 1'b0, 1'b0);
    accept();
    m_req_valid[2] = 1'b0;
    respond(7, 0);

    // Valid response held by master back-pressure does not age the watchdog
    m_req_valid = 4'b1000;
    push(3, 1'b0, 1'b0);
    accept();
    m_req_valid[3] = 1'b0;
    respond(3, 6);

    // Reset in REQ: rr_ptr back to 0 so master 0 beats master 3
    m_req_valid = 4'b0100;
    push(2, 1'b0, 1'b0);
    accept();
    m_req_valid[2] = 1'b0;
    respond(1, 0);
    s0_req_ready = 1'b0;
    m_req_valid  = 4'b0001;
    #1;
    chk("rstreq_fwd", obs_s0_req_valid, 1);
    nxt();
    rst = 1'b1;
    m_req_valid = '0;
    nxt();
    rst = 1'b0;
    #1;
    chk_idle("rst_in_req");
    m_req_valid = 4'b1001;
    push(0, 1'b0, 1'b0);
    accept();

    // Reset in RESP abandons the transaction
    rst = 1'b1;
    m_req_valid   = '0;
    s0_resp_valid = 1'b1;
    s0_resp_data  = cap ^ MASK;
    nxt();
    rst = 1'b0;
    #1;
    chk_idle("rst_in_resp");
    void'(sb.pop_front());
    s0_resp_valid = 1'b0;
    m_req_valid = 4'b1100;
    push(2, 1'b0, 1'b0);
    accept();
    m_req_valid[2] = 1'b0;
    respond(0, 0);

    chk("scoreboard_empty", 256'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
